// File: rtl/mult_issue_ctrl.sv
// Multiply/divide sequencer for the mult issue slot: fixed-latency multiply,
// radix-2 restoring divide, result held under a valid/ready handshake.
module mult_issue_ctrl #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned PREG_W  = 7,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [XLEN-1:0]   in_d1,
  input  logic [XLEN-1:0]   in_d2,
  input  logic [PREG_W-1:0] in_dst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_data,
  output logic [PREG_W-1:0] out_dst,
  output logic              busy
);

  localparam int unsigned CNT_MAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
  localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] MUL_CNT0 = CNT_W'((MUL_LAT >= 2) ? MUL_LAT - 2 : 0);
  localparam logic [CNT_W-1:0] DIV_CNT0 = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        op_q;
  logic [PREG_W-1:0] dst_q;
  logic [XLEN-1:0]   a_q, b_q, rem_q;
  logic              negq_q, negr_q;
  logic              out_valid_q;
  logic [XLEN-1:0]   out_data_q;
  logic [PREG_W-1:0] out_dst_q;

  // One shared multiplier: fed straight from the issue slot in IDLE (for
  // MUL_LAT==1) and from the latched operands otherwise.
  logic [1:0]        m_op;
  logic [XLEN-1:0]   m_a, m_b, mul_res;
  logic              a_sx, b_sx;
  logic [2*XLEN-1:0] ax, bx, prod;

  logic [XLEN:0]     r_sh;
  logic              ge;
  logic [XLEN-1:0]   rem_d, quo_d, q_fin, r_fin, div_res;

  logic              in_signed, d1_neg, d2_neg, div0, ovf;
  logic [XLEN-1:0]   spec_res, abs1, abs2;

  always_comb begin
    m_op    = (state_q == ST_IDLE) ? in_op[1:0] : op_q;
    m_a     = (state_q == ST_IDLE) ? in_d1 : a_q;
    m_b     = (state_q == ST_IDLE) ? in_d2 : b_q;
    a_sx    = ((m_op == 2'b01) || (m_op == 2'b10)) && m_a[XLEN-1];
    b_sx    = (m_op == 2'b01) && m_b[XLEN-1];
    ax      = {{XLEN{a_sx}}, m_a};
    bx      = {{XLEN{b_sx}}, m_b};
    prod    = ax * bx;
    mul_res = (m_op == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    r_sh    = {rem_q, a_q[XLEN-1]};
    ge      = (r_sh >= {1'b0, b_q});
    rem_d   = ge ? (r_sh[XLEN-1:0] - b_q) : r_sh[XLEN-1:0];
    quo_d   = {a_q[XLEN-2:0], ge};
    q_fin   = negq_q ? -quo_d : quo_d;
    r_fin   = negr_q ? -rem_d : rem_d;
    div_res = op_q[1] ? r_fin : q_fin;

    in_signed = ~in_op[0];
    d1_neg    = in_signed & in_d1[XLEN-1];
    d2_neg    = in_signed & in_d2[XLEN-1];
    div0      = (in_d2 == '0);
    ovf       = in_signed && (in_d1 == MIN_NEG) && (in_d2 == '1);
    spec_res  = div0 ? (in_op[1] ? in_d1 : '1) : (in_op[1] ? '0 : in_d1);
    abs1      = d1_neg ? -in_d1 : in_d1;
    abs2      = d2_neg ? -in_d2 : in_d2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_dst_q   <= '0;
    end else if (flush) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (in_valid) begin
          op_q  <= in_op[1:0];
          dst_q <= in_dst;
          if (!in_op[2]) begin
            a_q <= in_d1;
            b_q <= in_d2;
            if (MUL_LAT == 1) begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
              out_data_q  <= mul_res;
              out_dst_q   <= in_dst;
            end else begin
              state_q <= ST_MUL;
              cnt_q   <= MUL_CNT0;
            end
          end else if (div0 || ovf) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
            out_data_q  <= spec_res;
            out_dst_q   <= in_dst;
          end else begin
            state_q <= ST_DIV;
            cnt_q   <= DIV_CNT0;
            a_q     <= abs1;
            b_q     <= abs2;
            rem_q   <= '0;
            negq_q  <= d1_neg ^ d2_neg;
            negr_q  <= d1_neg;
          end
        end
        ST_MUL: begin
          if (cnt_q == '0) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
            out_data_q  <= mul_res;
            out_dst_q   <= dst_q;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        // a_q doubles as the dividend shift register that collects quotient bits
        ST_DIV: begin
          a_q   <= quo_d;
          rem_q <= rem_d;
          if (cnt_q == '0) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
            out_data_q  <= div_res;
            out_dst_q   <= dst_q;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_DONE: if (out_ready) begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_dst   = out_dst_q;

endmodule

// File: doc/mult_issue_ctrl.md
# mult_issue_ctrl

Sequencer for the shared multiply/divide execution resource fed by the single mult issue slot. It accepts one operation at a time from issue/source-read, runs a fixed-latency multiply or an iterative radix-2 divide, and holds the result for writeback under a valid/ready handshake. It sits between the mult source slot and the writeback/commit stage, and is squashed by pipeline flush.

## Interface
- XLEN, 64: operand/result width.
- PREG_W, 7: physical destination register tag width.
- MUL_LAT, 3: multiply latency in cycles from accept to out_valid; legal values are ≥1.

- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  squash the in-flight op; synchronous.
- in_valid  in  1  issue slot holds an op.
- in_ready  out  1  unit can accept; high only in IDLE.
- in_op  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- in_d1, in_d2  in  XLEN  rs1 and rs2 operands.
- in_dst  in  PREG_W  destination tag.
- out_valid  out  1  result held.
- out_ready  in  1  writeback accepts the result.
- out_data  out  XLEN  result.
- out_dst  out  PREG_W  tag of the result.
- busy  out  1  state ≠ IDLE; feeds the issue stall logic.

## Operation
- **States:** IDLE, MUL, DIV, DONE.
- **Accept:** accept = in_valid & in_ready. On accept, latch op, d1, d2 and dst.
- **Multiply ops:**
  - With MUL_LAT=1, go directly to DONE.
  - Otherwise go to MUL with cnt = MUL_LAT-2, then decrement each cycle. Move to DONE when cnt==0.
  - Product is the full 2·XLEN result. Operand signedness: MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned.
  - MUL returns the low XLEN bits; the MULH variants return the high XLEN bits.
- **Divide ops, special cases** (go directly to DONE):
  - Divisor 0: quotient = all ones; remainder = dividend.
  - Signed overflow (d1 = 1<<(XLEN-1), d2 = all ones, DIV/REM only): quotient = d1; remainder = 0.
- **Divide ops, normal case** (enter DIV):
  - Take absolute values for signed ops.
  - Run restoring division, one quotient bit per cycle, using iteration counter cnt = XLEN-1 down to 0.
  - On the cycle cnt==0, apply sign fixup (quotient negated if the operand signs differ; remainder takes the dividend's sign), then go to DONE.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- **DONE:**
  - out_valid=1; out_data and out_dst stay stable until out_ready.
  - When out_ready is high, go to IDLE next cycle.
  - No accept in the same cycle as the handshake, because in_ready is low in DONE.
- **flush:**
  - From any state, next state is IDLE and out_valid drops next cycle.
  - flush overrides a simultaneous accept: the op is dropped and nothing is latched.
  - flush overrides a simultaneous out handshake: the writeback stage must also honour flush.
- **reset:**
  - Same effect as flush, plus every output register cleared.
  - Reset mid-divide aborts with no output.
- Only out_valid, out_data, out_dst and state are reset-visible; internal datapath registers need no reset.

## Timing
- **Reset values:** state=IDLE, in_ready=1, busy=0, out_valid=0, out_data=0, out_dst=0.
- **Multiply:** accept in cycle T → out_valid first high in cycle T+MUL_LAT.
- **Divide, normal case:** accept in T → DIV occupies cycles T+1..T+XLEN → out_valid in T+XLEN+1.
- **Divide, special case:** out_valid in T+1.
- **Throughput:** at most one op in flight. The next accept can happen no earlier than one cycle after the out handshake.
- in_ready and busy are functions of registered state only. in_ready has no combinational path from in_valid or out_ready.
- While out_valid is high and out_ready is low, out_data and out_dst must not change.

## Test plan
- Reset then idle: reset=1 for 2 cycles → out_valid=0, out_data=0, in_ready=1, busy=0. MUL with d1=7, d2=-3, accepted at T → out_valid at T+3 with out_data=0xFFFF_FFFF_FFFF_FFEB and out_dst equal to in_dst.
- MULHU with d1=all ones, d2=2 → out_data=1. MULH with d1=-1, d2=-1 → 0. MULHSU with d1=-1, d2=2 → all ones.
- DIV -7/2 → out_valid at T+65 with out_data=-3 (0xFFFF_FFFF_FFFF_FFFD). REM -7/2 → -1. DIVU 100/7 → 14. REMU 100/7 → 2.
- Special cases, all with out_valid at T+1:
  - DIVU 5/0 → all ones.
  - REM 5/0 → 5.
  - DIV 0x8000_0000_0000_0000 / -1 → 0x8000_0000_0000_0000.
  - REM with the same operands → 0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_valid and out_data stable and in_ready=0 throughout. Then raise out_ready → IDLE next cycle, and an op presented then is accepted one cycle later.
- Flush: flush in cycle T+20 of a DIV → IDLE and out_valid=0 at T+21, no result ever produced. Flush in the same cycle as an accept → op dropped. Reset asserted mid-MUL → all outputs at reset values next cycle.
